// File: rtl/gate_self_test.sv
// Exhaustive self-test sequencer for a 2-input gate.
// Ports: clk, reset_n, start, truth_table, y_in -> a_out, b_out, busy, done, pass, err_count, fail_vec.
module gate_self_test #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] truth_table,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] tt_q;
  logic       miss;
  logic [1:0] idx_nx;

  // 4-state compare so an X/Z response counts as a miss
  assign miss   = (y_in !== tt_q[idx]);
  assign idx_nx = idx + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      tt_q      <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            tt_q      <= truth_table;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            idx       <= 2'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (miss) begin
            err_count     <= err_count + 3'd1;
            fail_vec[idx] <= 1'b1;
          end
          if (idx == 2'd3) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !miss && (err_count == 3'd0);
            state <= DONE;
          end else begin
            idx   <= idx_nx;
            a_out <= idx_nx[1];
            b_out <= idx_nx[0];
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_self_test.sv
// Randomized self-checking bench for gate_self_test.
// Two instances: default settle (2) and settle of 1.
module tb_gate_self_test;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start0, start1;
  logic [3:0] tt0, tt1, g0, g1;
  logic       a0, b0, a1, b1;
  logic       busy0, busy1, done0, done1;
  logic       pass0, pass1;
  logic [2:0] ec0, ec1;
  logic [3:0] fv0, fv1;
  logic       y0, y1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // gate under test modelled as a lookup on {a,b}
  assign y0 = g0[{a0, b0}];
  assign y1 = g1[{a1, b1}];

  gate_self_test #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .truth_table(tt0), .y_in(y0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(ec0), .fail_vec(fv0)
  );

  gate_self_test #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .truth_table(tt1), .y_in(y1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(ec1), .fail_vec(fv1)
  );

  // {ab[11:10], busy[9], done[8], pass[7], ec[6:4], fv[3:0]}
  function automatic logic [11:0] obs(input bit sel);
    if (sel)
      return {a1, b1, busy1, done1, pass1, ec1, fv1};
    return {a0, b0, busy0, done0, pass0, ec0, fv0};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  // Wait (bounded) for done; returns edges counted from the start edge
  task automatic wait_done(input bit sel, input int s,
                           input bit chk_ab, output int n);
    logic [11:0] o;
    n = 1;
    o = obs(sel);
    while (!o[8] && n < 100) begin
      if (chk_ab)
        chk("ab_seq", 32'(o[11:10]), 32'((n - 1) / (s + 1)));
      @(posedge clk);
      n++;
      @(negedge clk);
      o = obs(sel);
    end
  endtask

  task automatic run(input bit sel, input logic [3:0] tt,
                     input logic [3:0] gate, input bit hold);
    int s;
    int lat;
    int n;
    logic [3:0] efv;
    logic [11:0] o;
    s   = sel ? 1 : 2;
    lat = 4 * (s + 1) + 1;
    efv = tt ^ gate;
    if (sel) begin tt1 = tt; g1 = gate; end
    else begin tt0 = tt; g0 = gate; end
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      if (sel) tt1 = 4'b0000;
      else tt0 = 4'b0000;
    end else begin
      set_start(sel, 1'b0);
    end
    o = obs(sel);
    chk("busy_run", 32'(o[9]), 1);
    wait_done(sel, s, 1'b1, n);
    o = obs(sel);
    chk("latency", n, lat);
    chk("err_count", 32'(o[6:4]), $countones(efv));
    chk("fail_vec", 32'(o[3:0]), 32'(efv));
    chk("pass", 32'(o[7]), 32'(efv == 4'd0));
    chk("busy_done", 32'(o[9]), 0);
    if (hold) begin
      // start still high in DONE: restart with the new table
      @(posedge clk);
      @(negedge clk);
      o = obs(sel);
      chk("restart_done", 32'(o[8]), 0);
      chk("restart_busy", 32'(o[9]), 1);
      set_start(sel, 1'b0);
      wait_done(sel, s, 1'b0, n);
      o = obs(sel);
      chk("restart_lat", n, lat);
      chk("restart_fv", 32'(o[3:0]), 32'(gate));
    end else begin
      repeat (3) @(negedge clk);
      o = obs(sel);
      chk("hold_done", 32'(o[8]), 1);
      chk("hold_fv", 32'(o[3:0]), 32'(efv));
    end
  endtask

  initial begin
    int n;
    logic [11:0] o;
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    tt0 = 4'd0; tt1 = 4'd0;
    g0 = 4'd0; g1 = 4'd0;
    #2;
    chk("reset0", 32'(obs(1'b0)), 0);
    chk("reset1", 32'(obs(1'b1)), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // AND gate, stuck-at-0, OR gate
    run(1'b0, 4'b1000, 4'b1000, 1'b0);
    run(1'b0, 4'b1000, 4'b0000, 1'b0);
    run(1'b0, 4'b1000, 4'b1110, 1'b0);

    // reset during settle of vector 2
    tt0 = 4'b1000; g0 = 4'b1000;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_ab", 32'(obs(1'b0) >> 10), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("abort0", 32'(obs(1'b0)), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, 4'b1000, 4'b1000, 1'b0);

    // start held high, table changed mid-run
    run(1'b0, 4'b1000, 4'b1000, 1'b1);

    // short settle instance
    run(1'b1, 4'b1000, 4'b1000, 1'b0);
    run(1'b1, 4'b1000, 4'b1110, 1'b1);

    // start ignored while busy (pulsed again mid-run)
    tt0 = 4'b0110; g0 = 4'b0110;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 6;
    o = obs(1'b0);
    while (!o[8] && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      o = obs(1'b0);
    end
    chk("busy_ignore_lat", n, 13);
    chk("busy_ignore_pass", 32'(o[7]), 1);

    for (int i = 0; i < 12; i++) begin
      run(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_self_test.md
GATE_SELF_TEST -- requirements
Module: gate_self_test

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, the number of cycles each input vector is held before y is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a test run.
REQ-005 The block SHALL have port truth_table  input  4  expected y per vector; bit i is the expected value for vector i = {a,b}.
REQ-006 The block SHALL have port y_in  input  1  output of the 2-input gate under test.
REQ-007 The block SHALL have ports a_out and b_out  output  1 each  registered drive to the gate under test inputs a and b.
REQ-008 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-009 The block SHALL have port done  output  1  high while results are valid.
REQ-010 The block SHALL have port pass  output  1  high when done and no mismatches occurred.
REQ-011 The block SHALL have port err_count  output  3  number of mismatching vectors, range 0..4.
REQ-012 The block SHALL have port fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE or DONE, start=1 at a clock edge SHALL:
- latch truth_table
- clear err_count and fail_vec
- set vector index idx=0 and drive {a_out,b_out}=2'b00
- load the settle counter
- enter SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with a_out=idx[1] and b_out=idx[0] held stable, then go to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle and compare y_in with latched truth_table[idx]; on mismatch it SHALL increment err_count and set fail_vec[idx].
REQ-017 From SAMPLE, idx<3 SHALL advance idx by 1, update a_out/b_out, reload the counter and return to SETTLE; idx=3 SHALL enter DONE.
REQ-018 Vector order SHALL be 00, 01, 10, 11 ({a,b}); idx SHALL never wrap within a run.
REQ-019 Latency from the edge sampling start to the first cycle with done=1 SHALL be 4*(SETTLE_CYCLES+1)+1 cycles, i.e. 13 at default.
REQ-020 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-021 done SHALL be 1 exactly in DONE.
REQ-022 pass SHALL equal done AND (err_count==0).
REQ-023 err_count and fail_vec SHALL hold their values in DONE until the next accepted start.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 truth_table changes after the start edge SHALL NOT affect the current run.
REQ-026 In DONE, start=1 SHALL restart per REQ-014, with done falling on the next cycle.
REQ-027 In simulation, a y_in of X or Z at SAMPLE SHALL count as a mismatch.

Reset
REQ-028 While reset_n=0, asynchronously and without waiting for clk, the block SHALL force:
- state = IDLE
- a_out=0, b_out=0, busy=0, done=0, pass=0
- err_count=0, fail_vec=0, idx=0.
REQ-029 Deassertion of reset_n SHALL leave the block in IDLE, and it SHALL accept start on the first rising edge after deassertion.
REQ-030 Assertion of reset_n mid-run SHALL abort the run with no partial results retained.

Verification
REQ-031 Scenario 1: truth_table=4'b1000, correct AND gate, start pulsed one cycle -> done=1 exactly 13 cycles later, pass=1, err_count=0, fail_vec=0000.
REQ-032 Scenario 2: truth_table=4'b1000, y_in stuck at 0 -> err_count=1, fail_vec=1000, pass=0.
REQ-033 Scenario 3: truth_table=4'b1000, OR gate as DUT -> err_count=2, fail_vec=0110, pass=0.
REQ-034 Scenario 4: reset_n pulsed low during SETTLE of vector 2 -> all outputs 0 immediately; a new start then gives a full 13-cycle run with correct results.
REQ-035 Scenario 5: start held high and truth_table changed to 4'b0000 mid-run -> no restart; results use the latched 4'b1000; after DONE, start still high restarts the run.
REQ-036 Scenario 6: SETTLE_CYCLES=1 -> a_out/b_out change every 2 cycles and done appears 9 cycles after start.
